// File: rtl/robo_pkg.sv
// Shared definitions for the wall-following robot controller.
//   - orientation codes (N/S/L/O)
//   - FSM state enum
//   - gira_esq(): heading after one 90-degree left turn (N->O->S->L->N)
package robo_pkg;

  localparam logic [1:0] ORI_N = 2'b00;
  localparam logic [1:0] ORI_S = 2'b01;
  localparam logic [1:0] ORI_L = 2'b10;
  localparam logic [1:0] ORI_O = 2'b11;

  typedef enum logic [2:0] {
    BUSCA,    // searching for a wall
    SEGUE,    // following the left wall
    VAO,      // forced advance after turning into a left gap
    REMOVE,   // removing debris ahead
    FIM,      // goal reached (left only by reset)
    TRAVADO   // turn limit hit (left only by reset)
  } robo_state_t;

  function automatic logic [1:0] gira_esq(input logic [1:0] orient);
    case (orient)
      ORI_N:   return ORI_O;
      ORI_O:   return ORI_S;
      ORI_S:   return ORI_L;
      default: return ORI_N;
    endcase
  endfunction

endpackage

// File: rtl/robo_odometria.sv
// Odometry for the robot controller.
// Inputs are the registered action outputs of the FSM; every register here
// therefore updates one cycle after the action it reflects.
//   clock, reset   : clock and synchronous active-high reset
//   avancar/girar/remover : actions issued during the current cycle
//   orientacao     : current heading, rotated left after each girar cycle
//   mov_count      : number of avancar cycles, saturating at all-ones
//   giros          : consecutive girar count, cleared by avancar/remover
module robo_odometria
  import robo_pkg::*;
#(
  parameter int         CNT_W       = 8,
  parameter int         GW          = 3,
  parameter logic [1:0] ORIENT_INIT = 2'b00
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             avancar,
  input  logic             girar,
  input  logic             remover,
  output logic [1:0]       orientacao,
  output logic [CNT_W-1:0] mov_count,
  output logic [GW-1:0]    giros
);

  logic [1:0]       orient_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [GW-1:0]    giros_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      orient_reg <= ORIENT_INIT;
      cnt_reg    <= '0;
      giros_reg  <= '0;
    end else begin
      if (girar)
        orient_reg <= gira_esq(orient_reg);
      // Saturate: at the maximum the move is still made but not counted.
      if (avancar && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
      if (avancar || remover)
        giros_reg <= '0;
      else if (girar)
        giros_reg <= giros_reg + GW'(1);
    end
  end

  assign orientacao = orient_reg;
  assign mov_count  = cnt_reg;
  assign giros      = giros_reg;

endmodule

// File: rtl/robo_seguidor_param.sv
// Parametrised left-wall-following robot controller (Moore FSM).
//   clock, reset : clock and synchronous active-high reset
//   enable       : 0 holds all state, action outputs forced to 0
//   head, left, under, barrier : sensors (barrier only meaningful with head)
//   avancar, girar, remover    : registered actions, at most one high
//   orientacao, mov_count      : odometry (see robo_odometria)
//   done, stuck  : sticky goal / stuck flags
module robo_seguidor_param
  import robo_pkg::*;
#(
  parameter int         REMOVE_CYCLES = 2,
  parameter int         MAX_GIROS     = 4,
  parameter int         CNT_W         = 8,
  parameter logic [1:0] ORIENT_INIT   = 2'b00
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             head,
  input  logic             left,
  input  logic             under,
  input  logic             barrier,
  output logic             avancar,
  output logic             girar,
  output logic             remover,
  output logic [1:0]       orientacao,
  output logic [CNT_W-1:0] mov_count,
  output logic             done,
  output logic             stuck
);

  localparam int GW = $clog2(MAX_GIROS + 1);
  localparam int RW = $clog2(REMOVE_CYCLES + 1);
  // A girar issued with this many turns already behind it hits the limit.
  localparam logic [GW-1:0] GIROS_LIM = GW'(MAX_GIROS - 1);
  // Removal cycles still owed after the entry cycle.
  localparam logic [RW-1:0] REM_LOAD  = RW'(REMOVE_CYCLES - 1);

  robo_state_t   state_reg, state_next;
  robo_state_t   mode_reg, mode_next;     // mode to resume after REMOVE
  logic [RW-1:0] rem_cnt_reg, rem_cnt_next;
  logic          avancar_reg, avancar_next;
  logic          girar_reg, girar_next;
  logic          remover_reg, remover_next;
  logic          done_reg, done_next;
  logic          stuck_reg, stuck_next;

  logic [GW-1:0] giros;
  logic [GW-1:0] giros_eff;
  robo_state_t   eval_mode, rule_mode, after_mode;
  logic          decide, want_girar;

  robo_odometria #(
    .CNT_W       (CNT_W),
    .GW          (GW),
    .ORIENT_INIT (ORIENT_INIT)
  ) u_odometria (
    .clock      (clock),
    .reset      (reset),
    .avancar    (avancar_reg),
    .girar      (girar_reg),
    .remover    (remover_reg),
    .orientacao (orientacao),
    .mov_count  (mov_count),
    .giros      (giros)
  );

  // The odometry turn count lags the action register by one cycle; fold the
  // action currently on the outputs in to get the count as of this edge.
  assign giros_eff = (avancar_reg || remover_reg) ? '0
                   : giros + {{(GW-1){1'b0}}, girar_reg};

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    rem_cnt_next = rem_cnt_reg;
    avancar_next = 1'b0;
    girar_next   = 1'b0;
    remover_next = 1'b0;
    done_next    = done_reg;
    stuck_next   = stuck_reg;
    eval_mode    = state_reg;
    rule_mode    = state_reg;
    after_mode   = state_reg;
    decide       = 1'b0;
    want_girar   = 1'b0;

    if (enable) begin
      case (state_reg)
        BUSCA, SEGUE, VAO: decide = 1'b1;
        REMOVE: begin
          if (rem_cnt_reg != '0) begin
            remover_next = 1'b1;
            rem_cnt_next = rem_cnt_reg - RW'(1);
          end else begin
            // Last removal cycle ends here: act as the saved mode.
            decide    = 1'b1;
            eval_mode = mode_reg;
          end
        end
        default: ;  // FIM / TRAVADO: hold
      endcase

      if (decide) begin
        if (under) begin
          state_next = FIM;
          done_next  = 1'b1;
        end else if (head && barrier) begin
          state_next   = REMOVE;
          mode_next    = eval_mode;
          remover_next = 1'b1;
          rem_cnt_next = REM_LOAD;
        end else begin
          // Finding a wall in BUSCA switches to SEGUE on the same edge.
          rule_mode = (eval_mode == BUSCA && left) ? SEGUE : eval_mode;
          case (rule_mode)
            SEGUE: begin
              if (!left) begin
                want_girar = 1'b1;
                after_mode = VAO;
              end else begin
                want_girar = head;
                after_mode = SEGUE;
              end
            end
            VAO: begin
              want_girar = head;
              after_mode = head ? VAO : SEGUE;
            end
            default: begin
              want_girar = head;
              after_mode = BUSCA;
            end
          endcase

          if (want_girar) begin
            if (giros_eff == GIROS_LIM) begin
              state_next = TRAVADO;
              stuck_next = 1'b1;
            end else begin
              girar_next = 1'b1;
              state_next = after_mode;
            end
          end else begin
            avancar_next = 1'b1;
            state_next   = after_mode;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= BUSCA;
      mode_reg    <= BUSCA;
      rem_cnt_reg <= '0;
      avancar_reg <= 1'b0;
      girar_reg   <= 1'b0;
      remover_reg <= 1'b0;
      done_reg    <= 1'b0;
      stuck_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      rem_cnt_reg <= rem_cnt_next;
      avancar_reg <= avancar_next;
      girar_reg   <= girar_next;
      remover_reg <= remover_next;
      done_reg    <= done_next;
      stuck_reg   <= stuck_next;
    end
  end

  assign avancar = avancar_reg;
  assign girar   = girar_reg;
  assign remover = remover_reg;
  assign done    = done_reg;
  assign stuck   = stuck_reg;

endmodule
